// File: rtl/timer_input_mux.sv
// timer_input_mux
//   Selects one of CHANNELS BCD timer-digit channels and registers its samples
//   onto a single output. The active channel can be changed on request, and the
//   output can be frozen with lock.
//
//   FSM: RUN    - sample the active channel whenever its strobe is high
//        SWITCH - one dead cycle after a channel change (strobes ignored)
//        LOCKED - output and active channel frozen while lock is high
//
// Ports
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   in_data    packed channel data, channel k = in_data[k*WIDTH +: WIDTH]
//   in_valid   per-channel sample strobe
//   sel        requested channel index
//   sel_load   request to make sel the active channel
//   lock       freeze the active channel and the output
//   out        registered sample of the active channel
//   out_valid  one-cycle strobe, new sample on out
//   sel_cur    active channel index
//   sel_err    one-cycle pulse, out-of-range request rejected
//   state_dbg  current FSM state (RUN=0, SWITCH=1, LOCKED=2)
//
// Handshake: a sample is a qualifier-only transfer. out carries a new sample
// exactly in the cycles where out_valid is 1; there is no back-pressure, so
// the consumer must take it in that cycle. sel_load and lock are level
// requests that are evaluated at every rising edge.
module timer_input_mux #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      sel_load,
    input  logic                      lock,
    output logic [WIDTH-1:0]          out,
    output logic                      out_valid,
    output logic [SEL_W-1:0]          sel_cur,
    output logic                      sel_err,
    output logic [1:0]                state_dbg
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_SWITCH = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // Every selector code gets a slot; codes past CHANNELS read as zero so
    // indexing by sel_cur is always in range.
    localparam int SLOTS = 1 << SEL_W;

    // CHANNELS as a (SEL_W+1)-bit value; fits because 2**SEL_W >= CHANNELS.
    localparam logic [SEL_W:0] CH_LIMIT = (SEL_W + 1)'(CHANNELS);

    logic [1:0]       state;
    logic [WIDTH-1:0] data_slot [SLOTS];
    logic [SLOTS-1:0] valid_slot;
    logic             sel_in_range;
    logic             req_ok;
    logic             req_bad;

    always_comb begin
        valid_slot = '0;
        for (int k = 0; k < SLOTS; k++) begin
            data_slot[k] = '0;
        end
        for (int k = 0; k < CHANNELS; k++) begin
            data_slot[k]  = in_data[k*WIDTH +: WIDTH];
            valid_slot[k] = in_valid[k];
        end
    end

    assign sel_in_range = ({1'b0, sel} < CH_LIMIT);
    // Requesting the already-active channel is a silent no-op.
    assign req_ok  = sel_load && sel_in_range && (sel != sel_cur);
    assign req_bad = sel_load && !sel_in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            sel_cur   <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
            case (state)
                ST_RUN, ST_SWITCH: begin
                    if (lock) begin
                        // lock wins over any request in the same cycle; the
                        // request is dropped without an error pulse.
                        state <= ST_LOCKED;
                    end else begin
                        // The edge that accepts a request still samples the
                        // old channel; the dead cycle is the following one.
                        if (state == ST_RUN && valid_slot[sel_cur]) begin
                            out       <= data_slot[sel_cur];
                            out_valid <= 1'b1;
                        end
                        if (req_ok) begin
                            sel_cur <= sel;
                            state   <= ST_SWITCH;
                        end else begin
                            state   <= ST_RUN;
                            sel_err <= req_bad;
                        end
                    end
                end
                ST_LOCKED: begin
                    // Leaving LOCKED takes no sample and ignores requests;
                    // sampling restarts on the next edge.
                    if (!lock) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_timer_input_mux.sv
// Bench for timer_input_mux (WIDTH=4, CHANNELS=4, SEL_W=3 so out-of-range
// selector codes 4..7 exist). Directed steps pin literal values; a
// behavioural model is compared against the DUT on every falling edge,
// across the directed steps and a randomized run.
module tb_timer_input_mux;

    localparam int WIDTH    = 4;
    localparam int CHANNELS = 4;
    localparam int SEL_W    = 3;

    logic                      clk;
    logic                      rst;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [SEL_W-1:0]          sel;
    logic                      sel_load;
    logic                      lock;
    logic [WIDTH-1:0]          out;
    logic                      out_valid;
    logic [SEL_W-1:0]          sel_cur;
    logic                      sel_err;
    logic [1:0]                state_dbg;

    int checks = 0;
    int errors = 0;

    timer_input_mux #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .sel       (sel),
        .sel_load  (sel_load),
        .lock      (lock),
        .out       (out),
        .out_valid (out_valid),
        .sel_cur   (sel_cur),
        .sel_err   (sel_err),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks what the outputs must be after each edge: active channel, whether
    // a dead cycle follows a channel change, and whether the output is frozen.
    int         m_sel;
    int         m_out;
    bit         m_ov;
    bit         m_err;
    bit         m_dead;
    bit         m_frozen;
    bit         m_ok = 0;

    always @(posedge clk) begin
        bit ok_req;
        bit bad_req;
        if (rst) begin
            m_sel = 0; m_out = 0; m_ov = 0; m_err = 0;
            m_dead = 0; m_frozen = 0; m_ok = 1;
        end else if (m_ok) begin
            ok_req  = sel_load && (int'(sel) < CHANNELS) && (int'(sel) != m_sel);
            bad_req = sel_load && (int'(sel) >= CHANNELS);
            m_ov  = 0;
            m_err = 0;
            if (m_frozen) begin
                if (!lock) m_frozen = 0;
            end else if (lock) begin
                m_frozen = 1;
                m_dead   = 0;
            end else begin
                if (!m_dead && in_valid[m_sel]) begin
                    m_out = int'(in_data[m_sel*WIDTH +: WIDTH]);
                    m_ov  = 1;
                end
                m_err  = bad_req;
                m_dead = ok_req;
                if (ok_req) m_sel = int'(sel);
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (m_ok) begin
            chk("cmp_out",       32'(out),       32'(m_out));
            chk("cmp_out_valid", 32'(out_valid), 32'(m_ov));
            chk("cmp_sel_cur",   32'(sel_cur),   32'(m_sel));
            chk("cmp_sel_err",   32'(sel_err),   32'(m_err));
        end
    end

    // ---------------- driver ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = '0; sel = '0; sel_load = 1'b0; lock = 1'b0;
        cyc();
        cyc();
        chk("rst_out",       32'(out),       32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_sel_cur",   32'(sel_cur),   32'h0);
        chk("rst_sel_err",   32'(sel_err),   32'h0);

        // first sample after reset
        rst = 1'b0; in_data = {4'h3, 4'h2, 4'h1, 4'h7}; in_valid = 4'b0001;
        cyc();
        chk("first_out",   32'(out),       32'h7);
        chk("first_valid", 32'(out_valid), 32'h1);
        chk("first_sel",   32'(sel_cur),   32'h0);

        // switch to channel 2
        sel = 3'd2; sel_load = 1'b1;
        cyc();
        chk("sw_sel_cur", 32'(sel_cur), 32'h2);
        sel_load = 1'b0; in_valid = 4'b0100;
        cyc();
        chk("sw_dead_valid", 32'(out_valid), 32'h0);
        chk("sw_dead_out",   32'(out),       32'h7);
        cyc();
        chk("sw_new_out",   32'(out),       32'h2);
        chk("sw_new_valid", 32'(out_valid), 32'h1);

        // out-of-range request
        sel = 3'd5; sel_load = 1'b1; in_data = {4'h3, 4'h9, 4'h1, 4'h7};
        cyc();
        chk("err_pulse", 32'(sel_err),   32'h1);
        chk("err_sel",   32'(sel_cur),   32'h2);
        chk("err_out",   32'(out),       32'h9);
        chk("err_valid", 32'(out_valid), 32'h1);
        sel_load = 1'b0;
        cyc();
        chk("err_clear", 32'(sel_err), 32'h0);

        // lock with a simultaneous request
        lock = 1'b1; sel = 3'd1; sel_load = 1'b1;
        cyc();
        chk("lock_sel",   32'(sel_cur),   32'h2);
        chk("lock_valid", 32'(out_valid), 32'h0);
        chk("lock_err",   32'(sel_err),   32'h0);
        sel_load = 1'b0; in_data = {4'h3, 4'h4, 4'h1, 4'h7};
        cyc();
        chk("lock_frozen", 32'(out), 32'h9);
        lock = 1'b0;
        cyc();
        chk("unlock_no_sample", 32'(out_valid), 32'h0);
        cyc();
        chk("unlock_sample", 32'(out), 32'h4);

        // two requests on consecutive cycles
        sel = 3'd1; sel_load = 1'b1;
        cyc();
        chk("dbl_first_valid", 32'(out_valid), 32'h1);
        sel = 3'd3;
        cyc();
        chk("dbl_sel",    32'(sel_cur),   32'h3);
        chk("dbl_low1",   32'(out_valid), 32'h0);
        sel_load = 1'b0; in_valid = 4'b1000;
        cyc();
        chk("dbl_low2",   32'(out_valid), 32'h0);
        cyc();
        chk("dbl_out",    32'(out),       32'h3);
        chk("dbl_valid",  32'(out_valid), 32'h1);

        // reset during SWITCH
        sel = 3'd1; sel_load = 1'b1;
        cyc();
        rst = 1'b1; sel_load = 1'b0;
        cyc();
        chk("rsw_out",   32'(out),       32'h0);
        chk("rsw_sel",   32'(sel_cur),   32'h0);
        chk("rsw_valid", 32'(out_valid), 32'h0);
        rst = 1'b0; in_valid = 4'b0001;
        cyc();
        chk("rsw_sample", 32'(out), 32'h7);

        // randomized run
        for (int n = 0; n < 4000; n++) begin
            rst      = ($urandom_range(0, 79) == 0);
            in_data  = CHANNELS*WIDTH'($urandom);
            in_valid = CHANNELS'($urandom_range(0, 15));
            sel      = SEL_W'($urandom_range(0, 7));
            sel_load = ($urandom_range(0, 3) == 0);
            lock     = ($urandom_range(0, 9) < 2);
            cyc();
        end

        rst = 1'b0; sel_load = 1'b0; lock = 1'b0;
        cyc();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_input_mux.md
TIMER_INPUT_MUX -- requirements
Module: timer_input_mux

Interface
REQ-001 Parameter WIDTH, default 4, bit width of each channel (one BCD timer digit).
REQ-002 Parameter CHANNELS, default 4, number of input channels; legal range 2..16.
REQ-003 Parameter SEL_W, default 2, selector width; SHALL satisfy 2**SEL_W >= CHANNELS.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_data  input  CHANNELS*WIDTH  packed channel data; channel k = bits [k*WIDTH +: WIDTH].
REQ-007 in_valid  input  CHANNELS  per-channel sample strobe.
REQ-008 sel  input  SEL_W  requested channel index.
REQ-009 sel_load  input  1  request to switch the active channel to sel.
REQ-010 lock  input  1  freeze active channel and output.
REQ-011 out  output  WIDTH  registered data from the active channel.
REQ-012 out_valid  output  1  one-cycle strobe marking a new sample on out.
REQ-013 sel_cur  output  SEL_W  currently active channel index.
REQ-014 sel_err  output  1  one-cycle pulse on a rejected out-of-range request.

Function
REQ-015 The block SHALL implement the states RUN, SWITCH and LOCKED.
REQ-016 RUN: on each edge with in_valid[sel_cur]=1, out <= channel sel_cur and out_valid <= 1; otherwise out holds and out_valid <= 0.
REQ-017 Data latency SHALL be exactly 1 cycle, in_valid at edge n -> out/out_valid visible after edge n.
REQ-018 Request accept: sel_load=1, lock=0, sel < CHANNELS, sel != sel_cur -> sel_cur <= sel at that edge, state -> SWITCH.
REQ-019 SWITCH: lasts exactly 1 cycle; out holds, out_valid = 0, in_valid ignored; then -> RUN (new channel sampled from the following edge).
REQ-020 sel_load with sel == sel_cur SHALL be a no-op: no SWITCH cycle, no sel_err, sampling continues uninterrupted.
REQ-021 sel_load with sel >= CHANNELS SHALL leave sel_cur and state unchanged and pulse sel_err for 1 cycle; RUN sampling continues that cycle.
REQ-022 sel_load accepted while in SWITCH SHALL update sel_cur and restart SWITCH for another single cycle.
REQ-023 lock=1 in RUN or SWITCH -> LOCKED at that edge; LOCKED: out and sel_cur hold, out_valid = 0.
REQ-024 lock deasserted in LOCKED -> RUN at that edge; first sample no earlier than the next edge.
REQ-025 Simultaneous lock and sel_load: lock wins; request discarded (not queued), no sel_err even if sel out of range.
REQ-026 sel_err and out_valid SHALL never stay high more than one cycle per triggering event; they SHALL be registered outputs.
REQ-027 Valid strobes on non-selected channels SHALL have no effect.

Reset
REQ-028 rst=1 at an edge SHALL force state RUN, sel_cur 0, out 0, out_valid 0, sel_err 0, overriding every other input.
REQ-029 Reset mid-SWITCH or mid-LOCKED SHALL abort to RUN with channel 0; pending requests are lost.
REQ-030 First sample after reset release SHALL be taken on the first edge with rst=0 and in_valid[0]=1.

Verification (WIDTH=4, CHANNELS=4)
REQ-031 Reset, then in_data={4'h3,4'h2,4'h1,4'h7}, in_valid=4'b0001 -> out=7, out_valid=1 one cycle later; sel_cur=0.
REQ-032 sel=2, sel_load pulse -> sel_cur=2, one cycle out_valid=0 with out held at 7, then in_valid[2]=1 -> out=2, out_valid=1.
REQ-033 SEL_W=3 build, sel=5, sel_load -> sel_err pulse 1 cycle, sel_cur unchanged, ongoing samples unaffected.
REQ-034 lock=1 with sel=1 and sel_load same cycle -> LOCKED, sel_cur unchanged, out frozen, no out_valid, no sel_err; lock=0 -> sampling resumes next edge.
REQ-035 Two accepted requests on consecutive cycles (sel 1 then 3) -> sel_cur=3, out_valid low for exactly 2 cycles total.
REQ-036 rst asserted during SWITCH -> out=0, sel_cur=0, out_valid=0 next cycle; in_valid[0]=1 afterwards -> channel 0 data appears after 1 cycle.
